config_uart_tx: RTL and testbench
=================================

Name: config_uart_tx

Overview:
UART transmit end of the host command link. Runs the return path for the command parser's "report configuration" sequence. On each tx_valid request, the block reads the addressed parameter byte, taken from the time-parameter register file or the run/ramsey status bits. It then serialises that byte as one 8N1 frame on uart_txd.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (434 at the defaults).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
tx_valid  in  1  send request. The block acts on its rising edge only; the level is held for many cycles by the parser.
tx_address  in  4  parameter select: 0..7 time parameter, 8 status, 15 none.
txbyte_pos  in  1  0 = low byte, 1 = high byte.
rd_addr  out  3  time register file read address. Read latency is 1 cycle.
rd_data  in  16  time register file read data.
isrun  in  1  current run/stop flag.
isramsey  in  1  current ramsey/rabi flag.
uart_txd  out  1  serial output; idles high.
tx_busy  out  1  high from request acceptance until the stop bit completes.
tx_overrun  out  1  sticky flag: a request edge arrived while busy.

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high.
- Reset values: uart_txd=1, tx_busy=0, tx_overrun=0, rd_addr=0, FSM=IDLE, all counters 0, tx_valid edge register=0.
- Edge detect: a request is tx_valid=1 this cycle with tx_valid=0 on the previous cycle. The registered previous value is cleared by reset.
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP (plus PARITY when PARITY_EN is defined).
- IDLE: on a request, sample tx_address and txbyte_pos.
  - tx_address=15 or 9..14: discard the request; no frame, no overrun.
  - Otherwise: go to FETCH and set tx_busy=1 on the next edge.
- FETCH: drive rd_addr = sampled address[2:0] for one cycle.
- LOAD: latch the shift byte.
  - Address 0..7: rd_data[7:0] when pos=0, rd_data[15:8] when pos=1.
  - Address 8: {6'b0, isramsey, isrun} when pos=0, 8'h00 when pos=1.
  - The byte is a snapshot; later input changes do not affect the frame in flight.
- START: uart_txd=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7; after bit 7 go to STOP.
- STOP: uart_txd=1 for CLKS_PER_BIT cycles, then IDLE with tx_busy=0 on the same edge.
- Latency: request sampled on edge N → FETCH at N+1 → LOAD at N+2 → start bit on uart_txd from edge N+3. A frame occupies 10*CLKS_PER_BIT cycles (4340 at the defaults), which fits inside the parser's 5000-cycle byte window.
- Busy collisions: a request edge while tx_busy=1 is dropped and sets tx_overrun=1. tx_overrun clears only on rst.
- Back-to-back requests: a request edge on the same cycle STOP finishes is dropped (busy is still high) and counted as overrun.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps, and is cleared on every state change.
- Reset mid-frame: uart_txd returns to 1 on the next edge; no partial-frame recovery.

Optional Feature:
CONFIG_UART_TX_PARITY_EN: when defined, a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 11-bit frame (4774 cycles at the defaults). When undefined, the frame is plain 8N1 with no PARITY state.

Decomposition:
- Shared package contains:
  - the CLKS_PER_BIT computation function;
  - ADDR_STATUS=4'd8 and ADDR_NONE=4'd15;
  - NUM_TIME_PARAMS=8;
  - the tx FSM state enum.
- Sub-module uart_tx_byte: byte serialiser with a start/busy handshake, containing the baud counter, bit index and parity. config_uart_tx itself keeps the edge detect, the address decode and fetch, and overrun tracking.

Test Plan:
- Status byte: isrun=1, isramsey=0, tx_address=8, pos=0, tx_valid rise → line low from edge N+3; data bits LSB first 1,0,0,0,0,0,0,0; stop high; tx_busy low after 4340+3 cycles.
- Time parameter, both bytes: register 3 = 16'hA55A; addr 3, pos 0 → frame 0x5A; then addr 3, pos 1 → frame 0xA5; rd_addr=3 during FETCH.
- Full report sequence: drive the parser-style sequence (addr 0..7 pos 0/1, then addr 8 pos 0) with tx_valid high for 4201 cycles in each 5000-cycle window → 17 frames decoded in order, tx_overrun=0.
- Collision and ignored address: second rising edge 1000 cycles into a frame → that frame completes unchanged, no extra frame, tx_overrun=1. Separately, addr 15 → no frame, tx_busy stays 0.
- Reset mid-frame: rst during bit 4 → uart_txd=1, tx_busy=0, tx_overrun=0 next cycle; a following request transmits normally.
- Parity build (CONFIG_UART_TX_PARITY_EN defined): byte 0x07 → parity bit 1, 11-bit frame, 4774 cycles.

Source files
------------

// File: rtl/config_uart_tx_pkg.sv
// Shared types and constants for the configuration-report UART transmitter.
// Holds the baud divider helper, address map constants and the tx FSM state enum.
package config_uart_tx_pkg;

  localparam logic [3:0] ADDR_STATUS     = 4'd8;
  localparam logic [3:0] ADDR_NONE       = 4'd15;
  localparam int         NUM_TIME_PARAMS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } tx_state_e;

  // Truncating divide; a zero baud would be a configuration error, so clamp to 1.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    int unsigned cpb;
    cpb = (baud == 0) ? 1 : clk_freq / baud;
    return (cpb == 0) ? 1 : cpb;
  endfunction

  function automatic logic addr_is_valid(input logic [3:0] addr);
    return (addr < 4'(NUM_TIME_PARAMS)) || (addr == ADDR_STATUS);
  endfunction

endpackage

// File: rtl/config_uart_tx_byte.sv
// Byte serialiser: start pulse in, one 8N1 (or 8E1) frame out, done pulse on the
// final edge of the stop bit. Owns the baud counter, bit index and parity.
//
// state     | meaning
// ST_IDLE   | line high, waiting for start_i
// ST_START  | start bit (low)
// ST_DATA   | 8 data bits, LSB first
// ST_PARITY | even-parity bit (CONFIG_UART_TX_PARITY_EN only)
// ST_STOP   | stop bit (high)
module uart_tx_byte
  import config_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       txd_o,
  output logic       done_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             txd_q;
`ifdef CONFIG_UART_TX_PARITY_EN
  logic             parity_q;
`endif

  logic bit_end;
  assign bit_end = (baud_cnt_q == CNT_LAST);

  assign txd_o  = txd_q;
  assign done_o = (state_q == ST_STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
`ifdef CONFIG_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          baud_cnt_q <= '0;
          if (start_i) begin
            shift_q   <= data_i;
            bit_idx_q <= '0;
            txd_q     <= 1'b0;
            state_q   <= ST_START;
`ifdef CONFIG_UART_TX_PARITY_EN
            parity_q  <= ^data_i;
`endif
          end
        end

        ST_START: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            txd_q      <= shift_q[0];
            state_q    <= ST_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        // shift_q[0] is always the bit currently on the line
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef CONFIG_UART_TX_PARITY_EN
              txd_q   <= parity_q;
              state_q <= ST_PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

`ifdef CONFIG_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            txd_q      <= 1'b1;
            state_q    <= ST_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            txd_q      <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        default: begin
          baud_cnt_q <= '0;
          txd_q      <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/config_uart_tx.sv
// Return-path UART for the "report configuration" command: fetches one parameter
// byte and sends it as a frame. Define CONFIG_UART_TX_PARITY_EN for 8E1 frames.
//
// state    | meaning
// ST_IDLE  | waiting for a tx_valid rising edge
// ST_FETCH | rd_addr presented to the time register file
// ST_LOAD  | read data (or status bits) latched, serialiser kicked
// ST_START | serialiser owns the line until its stop bit completes
module config_uart_tx
  import config_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic [3:0]  tx_address,
  input  logic        txbyte_pos,
  output logic [2:0]  rd_addr,
  input  logic [15:0] rd_data,
  input  logic        isrun,
  input  logic        isramsey,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        tx_overrun
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);

  tx_state_e   state_q;
  logic        tx_valid_q;
  logic [3:0]  addr_q;
  logic        pos_q;
  logic [2:0]  rd_addr_q;
  logic [7:0]  byte_q;
  logic        start_q;
  logic        busy_q;
  logic        overrun_q;

  logic        req;
  logic [7:0]  load_byte_d;
  logic        ser_done;

  assign req = tx_valid && !tx_valid_q;

  always_comb begin
    load_byte_d = pos_q ? rd_data[15:8] : rd_data[7:0];
    if (addr_q == ADDR_STATUS) begin
      load_byte_d = pos_q ? 8'h00 : {6'b0, isramsey, isrun};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      addr_q     <= '0;
      pos_q      <= 1'b0;
      rd_addr_q  <= '0;
      byte_q     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      tx_valid_q <= tx_valid;
      start_q    <= 1'b0;

      // Includes the edge on which the stop bit ends: busy_q is still high there.
      if (req && busy_q) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (req && addr_is_valid(tx_address)) begin
            addr_q    <= tx_address;
            pos_q     <= txbyte_pos;
            rd_addr_q <= tx_address[2:0];
            busy_q    <= 1'b1;
            state_q   <= ST_FETCH;
          end
        end

        ST_FETCH: state_q <= ST_LOAD;

        ST_LOAD: begin
          byte_q  <= load_byte_d;
          start_q <= 1'b1;
          state_q <= ST_START;
        end

        ST_START: begin
          if (ser_done) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_tx_byte (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_q),
    .data_i (byte_q),
    .txd_o  (uart_txd),
    .done_o (ser_done)
  );

  assign rd_addr    = rd_addr_q;
  assign tx_busy    = busy_q;
  assign tx_overrun = overrun_q;

endmodule

// File: tb/tb_config_uart_tx.sv
// Directed bench for config_uart_tx, run with a 10-clock bit period so the full
// 17-frame report fits a short run; parser windows are scaled to match.
module tb_config_uart_tx;

  localparam int unsigned CLK_FREQ = 50000000;
  localparam int unsigned BAUD     = 5000000;
  localparam int          C        = CLK_FREQ / BAUD;
`ifdef CONFIG_UART_TX_PARITY_EN
  localparam int          NB       = 11;
`else
  localparam int          NB       = 10;
`endif
  localparam int          WINDOW   = 115;
  localparam int          HOLD     = 97;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid = 1'b0;
  logic [3:0]  tx_address = 4'd0;
  logic        txbyte_pos = 1'b0;
  logic        isrun = 1'b0;
  logic        isramsey = 1'b0;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        uart_txd;
  logic        tx_busy;
  logic        tx_overrun;

  logic [15:0] regs [8];
  logic [15:0] r;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hold_at = 0;
  int coll_at = 0;
  int flip_at = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= regs[rd_addr];

  config_uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_address(tx_address),
    .txbyte_pos(txbyte_pos),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .isrun     (isrun),
    .isramsey  (isramsey),
    .uart_txd  (uart_txd),
    .tx_busy   (tx_busy),
    .tx_overrun(tx_overrun)
  );

  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (cyc == hold_at) tx_valid = 1'b0;
    if (cyc == coll_at) tx_valid = 1'b1;
    if (cyc == flip_at) begin
      isrun    = ~isrun;
      isramsey = ~isramsey;
    end
  endtask

  // Issues one request and checks the whole frame edge by edge from edge N.
  task automatic frame(input logic [3:0] addr, input logic pos, input logic [7:0] exp,
                       input int hold, input int coll, input int flip, input string tag);
    @(negedge clk);
    tx_address = addr;
    txbyte_pos = pos;
    tx_valid   = 1'b1;
    cyc        = 0;
    hold_at    = hold;
    coll_at    = coll;
    flip_at    = flip;
    step();
    chk(tx_busy, 1, {tag, " busy@N"});
    chk(rd_addr, addr[2:0], {tag, " rd_addr"});
    step();
    step();
    chk(uart_txd, 1, {tag, " line@N+2"});
    step();
    chk(uart_txd, 0, {tag, " start@N+3"});
    repeat (C / 2) step();
    chk(uart_txd, 0, {tag, " start mid"});
    for (int k = 0; k < 8; k++) begin
      repeat (C) step();
      chk(uart_txd, exp[k], $sformatf("%s d%0d", tag, k));
    end
`ifdef CONFIG_UART_TX_PARITY_EN
    repeat (C) step();
    chk(uart_txd, ^exp, {tag, " parity"});
`endif
    repeat (C) step();
    chk(uart_txd, 1, {tag, " stop"});
    repeat (C / 2 - 1) step();
    chk(tx_busy, 1, {tag, " busy last"});
    step();
    chk(tx_busy, 0, {tag, " busy end"});
  endtask

  task automatic no_frame(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tx_busy || !uart_txd) seen = 1'b1;
    end
    chk(seen, 0, tag);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = {4'(i), 4'hC, 4'(15 - i), 4'h3};
    regs[3] = 16'hA55A;
    regs[5] = 16'h3C07;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(uart_txd, 1, "rst txd");
    chk(tx_busy, 0, "rst busy");
    chk(tx_overrun, 0, "rst overrun");
    chk(rd_addr, 0, "rst rd_addr");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Status byte; inputs flip mid-frame and must not affect the frame in flight.
    isrun    = 1'b1;
    isramsey = 1'b0;
    frame(4'd8, 1'b0, 8'h01, 20, 0, 10, "status");

    frame(4'd3, 1'b0, 8'h5A, 20, 0, 0, "t3lo");
    frame(4'd3, 1'b1, 8'hA5, 20, 0, 0, "t3hi");

    @(negedge clk);
    tx_address = 4'd15;
    tx_valid   = 1'b1;
    no_frame(150, "addr15 no frame");
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    tx_address = 4'd9;
    tx_valid   = 1'b1;
    no_frame(150, "addr9 no frame");
    chk(tx_overrun, 0, "ignored no overrun");
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Parser-style report: isrun=0, isramsey=1 after the earlier flip.
    for (int a = 0; a < 8; a++) begin
      for (int p = 0; p < 2; p++) begin
        r = regs[a];
        frame(4'(a), 1'(p), (p == 1) ? r[15:8] : r[7:0], HOLD, 0, 0,
              $sformatf("rpt%0d_%0d", a, p));
        while (cyc < WINDOW - 1) step();
      end
    end
    frame(4'd8, 1'b0, 8'h02, HOLD, 0, 0, "rpt status");
    while (cyc < WINDOW - 1) step();
    chk(tx_overrun, 0, "rpt overrun");

    // Second rising edge 30 cycles into a frame.
    frame(4'd3, 1'b0, 8'h5A, 10, 30, 0, "coll");
    chk(tx_overrun, 1, "coll overrun");
    no_frame(150, "coll no extra");
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during data bit 4 (regs[2] high byte 0x2C: bit 4 is 0).
    tx_address = 4'd2;
    txbyte_pos = 1'b1;
    tx_valid   = 1'b1;
    repeat (4 + 5 * C + C / 2) @(posedge clk);
    #1;
    chk(uart_txd, 0, "pre-rst bit4");
    @(negedge clk);
    rst      = 1'b1;
    tx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk(uart_txd, 1, "midrst txd");
    chk(tx_busy, 0, "midrst busy");
    chk(tx_overrun, 0, "midrst overrun");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    r = regs[2];
    frame(4'd2, 1'b1, r[15:8], 20, 0, 0, "after rst");

    // Request edge exactly on the edge the stop bit ends.
    r = regs[4];
    frame(4'd4, 1'b0, r[7:0], 20, 3 + NB * C, 0, "b2b");
    chk(tx_overrun, 1, "b2b overrun");
    no_frame(150, "b2b no extra");
    @(negedge clk);
    tx_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
